// File: rtl/exec_pkg.sv
// Shared types and constants for the execute stage and its operand resolvers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package exec_pkg;

    // Multi-cycle sequencing: IDLE accepts ops, ISSUE holds a request,
    // WAIT expects the response, DRAIN swallows the response of a flushed op.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // id_unit value that selects the external single-cycle ALU
    localparam int UNIT_ALU = 0;

    // Architectural zero register (reads 0 in both int and float classes)
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/operand_fwd.sv
// Resolves one source operand: zero register, own EX result, forward sources, regfile.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
// Ports: addr_i/is_f_i (operand address + class), ex_* (own EX register),
//        fwd_* (NFWD packed forward sources, index 0 highest priority),
//        rf_data_i (register-file read), data_o (resolved value).
module operand_fwd
    import exec_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RADDR = 5,
    parameter int NFWD  = 2
) (
    input  logic [RADDR-1:0]      addr_i,
    input  logic                  is_f_i,
    input  logic                  ex_hit_i,
    input  logic [RADDR-1:0]      ex_rd_i,
    input  logic                  ex_rd_f_i,
    input  logic [XLEN-1:0]       ex_data_i,
    input  logic [NFWD-1:0]       fwd_valid_i,
    input  logic [NFWD-1:0]       fwd_f_i,
    input  logic [NFWD*RADDR-1:0] fwd_rd_i,
    input  logic [NFWD*XLEN-1:0]  fwd_data_i,
    input  logic [XLEN-1:0]       rf_data_i,
    output logic [XLEN-1:0]       data_o
);

    always_comb begin
        data_o = rf_data_i;
        // Walk from lowest to highest priority so index 0 is applied last and wins.
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_valid_i[i] && (fwd_f_i[i] == is_f_i) &&
                (fwd_rd_i[i*RADDR +: RADDR] == addr_i)) begin
                data_o = fwd_data_i[i*XLEN +: XLEN];
            end
        end
        if (ex_hit_i && (ex_rd_f_i == is_f_i) && (ex_rd_i == addr_i)) begin
            data_o = ex_data_i;
        end
        // Register 0 is hardwired in both classes, regardless of any writer.
        if (addr_i == RADDR'(REG_ZERO)) begin
            data_o = '0;
        end
    end

endmodule

// File: rtl/exec_stage_mc.sv
// Execute stage: forwarded operands, single-cycle ALU path, multi-cycle unit dispatch, EX/MEM register.
// Latency: ALU ops 1 cycle; multi-cycle ops 1 + unit accept + unit response cycles.
// Backpressure: busy holds decode while a unit op is outstanding; drops in the response cycle.
// Ports: id_* (decode slot), rs*_data (regfile), fwd_* (later-stage forwards),
//        alu_* (external combinational ALU), mc_* (unit request/response),
//        busy (decode hold), ex_* (EX/MEM pipeline register).
module exec_stage_mc
    import exec_pkg::*;
#(
    parameter  int XLEN  = 32,
    parameter  int RADDR = 5,
    parameter  int NFWD  = 2,
    parameter  int NUNIT = 2,
    parameter  int CTLW  = 5,
    localparam int UW    = $clog2(NUNIT + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   id_valid,
    input  logic [CTLW-1:0]        id_ctl,
    input  logic [UW-1:0]          id_unit,
    input  logic [XLEN-1:0]        id_imm,
    input  logic [XLEN-1:0]        id_pc,
    input  logic                   id_src_imm,
    input  logic                   id_src_pc,
    input  logic [RADDR-1:0]       id_rs1,
    input  logic [RADDR-1:0]       id_rs2,
    input  logic [RADDR-1:0]       id_rd,
    input  logic                   id_rs1_f,
    input  logic                   id_rs2_f,
    input  logic                   id_rd_f,
    input  logic                   id_reg_write,
    input  logic                   id_mem_read,
    input  logic                   id_mem_write,
    input  logic [XLEN-1:0]        rs1_data,
    input  logic [XLEN-1:0]        rs2_data,
    input  logic [NFWD-1:0]        fwd_valid,
    input  logic [NFWD-1:0]        fwd_f,
    input  logic [NFWD*RADDR-1:0]  fwd_rd,
    input  logic [NFWD*XLEN-1:0]   fwd_data,
    output logic [XLEN-1:0]        alu_a,
    output logic [XLEN-1:0]        alu_b,
    output logic [CTLW-1:0]        alu_ctl,
    input  logic [XLEN-1:0]        alu_y,
    output logic [NUNIT-1:0]       mc_req_valid,
    input  logic [NUNIT-1:0]       mc_req_ready,
    output logic [CTLW-1:0]        mc_op,
    output logic [XLEN-1:0]        mc_a,
    output logic [XLEN-1:0]        mc_b,
    input  logic [NUNIT-1:0]       mc_resp_valid,
    input  logic [NUNIT*XLEN-1:0]  mc_resp_data,
    output logic                   busy,
    output logic                   ex_valid,
    output logic                   ex_reg_write,
    output logic                   ex_rd_f,
    output logic                   ex_mem_read,
    output logic                   ex_mem_write,
    output logic [RADDR-1:0]       ex_rd,
    output logic [XLEN-1:0]        ex_result,
    output logic [XLEN-1:0]        ex_store_data,
    output logic [XLEN-1:0]        ex_pc
);

    state_e            state_q, state_d;
    logic [UW-1:0]     unit_q, unit_d;
    logic [CTLW-1:0]   op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d;

    logic              ex_valid_q, ex_reg_write_q, ex_rd_f_q, ex_mem_read_q, ex_mem_write_q;
    logic [RADDR-1:0]  ex_rd_q;
    logic [XLEN-1:0]   ex_result_q, ex_store_data_q, ex_pc_q;

    logic [XLEN-1:0]   rs1_val, rs2_val, src1, src2;
    logic [NUNIT-1:0]  unit_sel;
    logic [XLEN-1:0]   resp_dat;
    logic              resp_hit, req_acc;
    logic              ex_ld;
    logic [XLEN-1:0]   ex_ld_res;

    operand_fwd #(.XLEN(XLEN), .RADDR(RADDR), .NFWD(NFWD)) u_fwd_rs1 (
        .addr_i(id_rs1), .is_f_i(id_rs1_f),
        .ex_hit_i(ex_valid_q && ex_reg_write_q), .ex_rd_i(ex_rd_q), .ex_rd_f_i(ex_rd_f_q),
        .ex_data_i(ex_result_q),
        .fwd_valid_i(fwd_valid), .fwd_f_i(fwd_f), .fwd_rd_i(fwd_rd), .fwd_data_i(fwd_data),
        .rf_data_i(rs1_data), .data_o(rs1_val)
    );

    operand_fwd #(.XLEN(XLEN), .RADDR(RADDR), .NFWD(NFWD)) u_fwd_rs2 (
        .addr_i(id_rs2), .is_f_i(id_rs2_f),
        .ex_hit_i(ex_valid_q && ex_reg_write_q), .ex_rd_i(ex_rd_q), .ex_rd_f_i(ex_rd_f_q),
        .ex_data_i(ex_result_q),
        .fwd_valid_i(fwd_valid), .fwd_f_i(fwd_f), .fwd_rd_i(fwd_rd), .fwd_data_i(fwd_data),
        .rf_data_i(rs2_data), .data_o(rs2_val)
    );

    assign src1    = id_src_pc  ? id_pc  : rs1_val;
    assign src2    = id_src_imm ? id_imm : rs2_val;
    assign alu_a   = src1;
    assign alu_b   = src2;
    assign alu_ctl = id_ctl;

    // Unit k lives on vector bit k-1; an out-of-range unit selects nothing
    // and the op can only leave ISSUE through a flush.
    always_comb begin
        unit_sel = '0;
        resp_dat = '0;
        for (int i = 0; i < NUNIT; i++) begin
            if (unit_q == UW'(i + 1)) begin
                unit_sel[i] = 1'b1;
                resp_dat    = mc_resp_data[i*XLEN +: XLEN];
            end
        end
    end

    assign resp_hit = |(mc_resp_valid & unit_sel);
    assign req_acc  = |(mc_req_ready & unit_sel);

    assign mc_req_valid = (state_q == ST_ISSUE) ? unit_sel : '0;
    assign mc_op        = op_q;
    assign mc_a         = a_q;
    assign mc_b         = b_q;

    assign busy = ((state_q == ST_IDLE) && id_valid && (id_unit != UW'(UNIT_ALU)) && !stall)
                || (state_q == ST_ISSUE) || (state_q == ST_DRAIN)
                || ((state_q == ST_WAIT) && !resp_hit);

    // Next state. Stall never sets ex_ld, so a flush always produces a bubble.
    always_comb begin
        state_d   = state_q;
        unit_d    = unit_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        ex_ld     = 1'b0;
        ex_ld_res = '0;
        case (state_q)
            ST_IDLE: begin
                if (id_valid && !stall) begin
                    if (id_unit == UW'(UNIT_ALU)) begin
                        ex_ld     = 1'b1;
                        ex_ld_res = alu_y;
                    end else begin
                        unit_d  = id_unit;
                        op_d    = id_ctl;
                        a_d     = src1;
                        b_d     = src2;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (stall)        state_d = ST_IDLE;
                else if (req_acc) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (stall) begin
                    state_d = resp_hit ? ST_IDLE : ST_DRAIN;
                end else if (resp_hit) begin
                    // Decode was held by busy, so id_* still describe this op.
                    ex_ld     = 1'b1;
                    ex_ld_res = resp_dat;
                    state_d   = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (resp_hit) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            unit_q          <= '0;
            op_q            <= '0;
            a_q             <= '0;
            b_q             <= '0;
            ex_valid_q      <= 1'b0;
            ex_reg_write_q  <= 1'b0;
            ex_rd_f_q       <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            ex_mem_write_q  <= 1'b0;
            ex_rd_q         <= '0;
            ex_result_q     <= '0;
            ex_store_data_q <= '0;
            ex_pc_q         <= '0;
        end else begin
            state_q         <= state_d;
            unit_q          <= unit_d;
            op_q            <= op_d;
            a_q             <= a_d;
            b_q             <= b_d;
            // The EX register advances every cycle; anything not loaded is a zeroed bubble.
            ex_valid_q      <= ex_ld;
            ex_reg_write_q  <= ex_ld && id_reg_write;
            ex_rd_f_q       <= ex_ld && id_rd_f;
            ex_mem_read_q   <= ex_ld && id_mem_read;
            ex_mem_write_q  <= ex_ld && id_mem_write;
            ex_rd_q         <= ex_ld ? id_rd   : '0;
            ex_result_q     <= ex_ld_res;
            ex_store_data_q <= ex_ld ? rs2_val : '0;
            ex_pc_q         <= ex_ld ? id_pc   : '0;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_reg_write  = ex_reg_write_q;
    assign ex_rd_f       = ex_rd_f_q;
    assign ex_mem_read   = ex_mem_read_q;
    assign ex_mem_write  = ex_mem_write_q;
    assign ex_rd         = ex_rd_q;
    assign ex_result     = ex_result_q;
    assign ex_store_data = ex_store_data_q;
    assign ex_pc         = ex_pc_q;

endmodule

// File: tb/tb_exec_stage_mc.sv
// Self-checking bench for exec_stage_mc: scripted cycles, retirement scoreboard.
// Latency: n/a.
// Backpressure: unit ready/response timing is scripted per scenario.
module tb_exec_stage_mc;

    localparam int XLEN  = 32;
    localparam int RADDR = 5;
    localparam int NFWD  = 2;
    localparam int NUNIT = 2;
    localparam int CTLW  = 5;
    localparam int UW    = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  stall;
    logic                  id_valid;
    logic [CTLW-1:0]       id_ctl;
    logic [UW-1:0]         id_unit;
    logic [XLEN-1:0]       id_imm, id_pc;
    logic                  id_src_imm, id_src_pc;
    logic [RADDR-1:0]      id_rs1, id_rs2, id_rd;
    logic                  id_rs1_f, id_rs2_f, id_rd_f;
    logic                  id_reg_write, id_mem_read, id_mem_write;
    logic [XLEN-1:0]       rs1_data, rs2_data;
    logic [NFWD-1:0]       fwd_valid, fwd_f;
    logic [NFWD*RADDR-1:0] fwd_rd;
    logic [NFWD*XLEN-1:0]  fwd_data;
    logic [XLEN-1:0]       alu_a, alu_b, alu_y;
    logic [CTLW-1:0]       alu_ctl;
    logic [NUNIT-1:0]      mc_req_valid, mc_req_ready, mc_resp_valid;
    logic [CTLW-1:0]       mc_op;
    logic [XLEN-1:0]       mc_a, mc_b;
    logic [NUNIT*XLEN-1:0] mc_resp_data;
    logic                  busy;
    logic                  ex_valid, ex_reg_write, ex_rd_f, ex_mem_read, ex_mem_write;
    logic [RADDR-1:0]      ex_rd;
    logic [XLEN-1:0]       ex_result, ex_store_data, ex_pc;

    typedef struct packed {
        logic [XLEN-1:0]  res;
        logic [RADDR-1:0] rd;
        logic             rd_f;
        logic [XLEN-1:0]  st;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // External ALU: ctl 0 = add, anything else = xor
    always_comb alu_y = (alu_ctl == 5'd0) ? (alu_a + alu_b) : (alu_a ^ alu_b);

    exec_stage_mc #(.XLEN(XLEN), .RADDR(RADDR), .NFWD(NFWD), .NUNIT(NUNIT), .CTLW(CTLW)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .id_valid(id_valid), .id_ctl(id_ctl), .id_unit(id_unit),
        .id_imm(id_imm), .id_pc(id_pc), .id_src_imm(id_src_imm), .id_src_pc(id_src_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_f(id_rs1_f), .id_rs2_f(id_rs2_f), .id_rd_f(id_rd_f),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .fwd_valid(fwd_valid), .fwd_f(fwd_f), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl), .alu_y(alu_y),
        .mc_req_valid(mc_req_valid), .mc_req_ready(mc_req_ready),
        .mc_op(mc_op), .mc_a(mc_a), .mc_b(mc_b),
        .mc_resp_valid(mc_resp_valid), .mc_resp_data(mc_resp_data),
        .busy(busy),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_rd_f(ex_rd_f),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_rd(ex_rd), .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_pc(ex_pc)
    );

    // Scoreboard: every retired EX entry must match the oldest expected one.
    always @(negedge clk) begin
        if (ex_valid === 1'b1) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected got result=%h rd=%0d, expected no retirement", ex_result, ex_rd);
            end else begin
                exp_t e;
                e = q.pop_front();
                if ({ex_result, ex_rd, ex_rd_f, ex_store_data} !== e) begin
                    bad++;
                    $display("FAIL sb_retire got res=%h rd=%0d f=%b st=%h want res=%h rd=%0d f=%b st=%h",
                             ex_result, ex_rd, ex_rd_f, ex_store_data, e.res, e.rd, e.rd_f, e.st);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        stall = 0; id_valid = 0; id_ctl = '0; id_unit = '0; id_imm = '0; id_pc = '0;
        id_src_imm = 0; id_src_pc = 0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_rs1_f = 0; id_rs2_f = 0; id_rd_f = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        rs1_data = '0; rs2_data = '0;
        fwd_valid = '0; fwd_f = '0; fwd_rd = '0; fwd_data = '0;
        mc_req_ready = '0; mc_resp_valid = '0; mc_resp_data = '0;
    endtask

    task automatic id_op(input logic [UW-1:0] unit, input logic [CTLW-1:0] ctl,
                         input logic [RADDR-1:0] rs1, input logic [RADDR-1:0] rs2,
                         input logic [RADDR-1:0] rd, input logic rd_f,
                         input logic src_imm, input logic [XLEN-1:0] imm);
        id_valid = 1; id_unit = unit; id_ctl = ctl; id_rs1 = rs1; id_rs2 = rs2;
        id_rd = rd; id_rd_f = rd_f; id_src_imm = src_imm; id_imm = imm;
        id_src_pc = 0; id_rs1_f = 0; id_rs2_f = 0; id_reg_write = 1;
        id_mem_read = 0; id_mem_write = 0;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1;
        tick();
        tick();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL rst_ex_valid got=%b want=0", ex_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (mc_req_valid !== 2'b00) begin bad++; $display("FAIL rst_req got=%b want=00", mc_req_valid); end
        total++; if (ex_result !== 32'h0) begin bad++; $display("FAIL rst_ex_result got=%h want=0", ex_result); end
        total++; if (mc_a !== 32'h0) begin bad++; $display("FAIL rst_mc_a got=%h want=0", mc_a); end
        rst = 0;
        tick();
    endtask

    task automatic test_back_to_back;
        // addi x1, x0, 5 (stale regfile value must be ignored for x0)
        id_op(2'd0, 5'd0, 5'd0, 5'd0, 5'd1, 1'b0, 1'b1, 32'd5);
        rs1_data = 32'd99; rs2_data = 32'd98;
        #1;
        total++; if (alu_a !== 32'd0) begin bad++; $display("FAIL b2b_x0 got=%h want=0", alu_a); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy0 got=%b want=0", busy); end
        q.push_back(exp_t'{32'd5, 5'd1, 1'b0, 32'd0});
        tick();
        // add x2, x1, x1 via own-EX forward
        id_op(2'd0, 5'd0, 5'd1, 5'd1, 5'd2, 1'b0, 1'b0, 32'd0);
        rs1_data = 32'd77; rs2_data = 32'd77;
        #1;
        total++; if (alu_a !== 32'd5 || alu_b !== 32'd5) begin bad++; $display("FAIL b2b_fwd got a=%h b=%h want 5,5", alu_a, alu_b); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy1 got=%b want=0", busy); end
        q.push_back(exp_t'{32'd10, 5'd2, 1'b0, 32'd5});
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_class_isolation;
        id_op(2'd0, 5'd0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 32'h3F800000);
        q.push_back(exp_t'{32'h3F800000, 5'd3, 1'b1, 32'd0});
        tick();
        // int x3 from regfile, float f3 from own EX, same cycle
        id_op(2'd0, 5'd0, 5'd3, 5'd3, 5'd4, 1'b0, 1'b0, 32'd0);
        id_rs2_f = 1; rs1_data = 32'd7; rs2_data = 32'h11;
        #1;
        total++; if (alu_a !== 32'd7) begin bad++; $display("FAIL cls_int got=%h want=7", alu_a); end
        total++; if (alu_b !== 32'h3F800000) begin bad++; $display("FAIL cls_float got=%h want=3f800000", alu_b); end
        q.push_back(exp_t'{32'h3F800007, 5'd4, 1'b0, 32'h3F800000});
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_priority;
        clear_inputs();
        id_rs1 = 5'd5; rs1_data = 32'd33;
        fwd_rd = {5'd5, 5'd5}; fwd_data = {32'd22, 32'd11}; fwd_valid = 2'b11;
        #1;
        total++; if (alu_a !== 32'd11) begin bad++; $display("FAIL pri_fwd0 got=%0d want=11", alu_a); end
        fwd_valid = 2'b10;
        #1;
        total++; if (alu_a !== 32'd22) begin bad++; $display("FAIL pri_fwd1 got=%0d want=22", alu_a); end
        fwd_valid = 2'b11; fwd_f = 2'b01;
        #1;
        total++; if (alu_a !== 32'd22) begin bad++; $display("FAIL pri_class got=%0d want=22", alu_a); end
        fwd_valid = 2'b00; fwd_f = 2'b00;
        #1;
        total++; if (alu_a !== 32'd33) begin bad++; $display("FAIL pri_rf got=%0d want=33", alu_a); end
        id_rs1 = 5'd0; fwd_rd = {5'd5, 5'd0}; fwd_valid = 2'b01;
        #1;
        total++; if (alu_a !== 32'd0) begin bad++; $display("FAIL pri_x0 got=%0d want=0", alu_a); end
        // own EX beats both forwards
        clear_inputs();
        id_op(2'd0, 5'd0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1, 32'd44);
        q.push_back(exp_t'{32'd44, 5'd5, 1'b0, 32'd0});
        tick();
        clear_inputs();
        id_rs1 = 5'd5; rs1_data = 32'd33;
        fwd_rd = {5'd5, 5'd5}; fwd_data = {32'd22, 32'd11}; fwd_valid = 2'b11;
        #1;
        total++; if (alu_a !== 32'd44) begin bad++; $display("FAIL pri_ex got=%0d want=44", alu_a); end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_multicycle;
        int busy_cnt;
        logic [NUNIT-1:0] exp_req;
        busy_cnt = 0;
        id_op(2'd1, 5'd3, 5'd0, 5'd0, 5'd6, 1'b0, 1'b1, 32'h20);
        id_src_pc = 1; id_pc = 32'h100;
        for (int c = 0; c <= 6; c++) begin
            mc_req_ready  = (c == 2) ? 2'b01 : 2'b00;
            mc_resp_valid = (c == 4) ? 2'b10 : ((c == 6) ? 2'b01 : 2'b00);
            mc_resp_data  = {32'hBAD, (c == 6) ? 32'hDEAD : 32'h0};
            #1;
            exp_req = (c == 1 || c == 2) ? 2'b01 : 2'b00;
            total++; if (mc_req_valid !== exp_req) begin bad++; $display("FAIL mc_req c=%0d got=%b want=%b", c, mc_req_valid, exp_req); end
            total++; if (busy !== (c < 6)) begin bad++; $display("FAIL mc_busy c=%0d got=%b want=%b", c, busy, (c < 6)); end
            if (busy === 1'b1) busy_cnt++;
            if (c == 1) begin
                total++;
                if (mc_a !== 32'h100 || mc_b !== 32'h20 || mc_op !== 5'd3) begin
                    bad++; $display("FAIL mc_latch got a=%h b=%h op=%0d want 100,20,3", mc_a, mc_b, mc_op);
                end
            end
            if (c == 6) q.push_back(exp_t'{32'hDEAD, 5'd6, 1'b0, 32'd0});
            tick();
        end
        total++; if (busy_cnt != 6) begin bad++; $display("FAIL mc_busy_cycles got=%0d want=6", busy_cnt); end
        // next op advances on the retire edge and sees the unit result via own-EX forward
        clear_inputs();
        id_op(2'd0, 5'd0, 5'd6, 5'd0, 5'd7, 1'b0, 1'b1, 32'd1);
        #1;
        total++; if (alu_a !== 32'hDEAD) begin bad++; $display("FAIL mc_fwd got=%h want=dead", alu_a); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mc_after_busy got=%b want=0", busy); end
        q.push_back(exp_t'{32'hDEAE, 5'd7, 1'b0, 32'd0});
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_flush_issue;
        id_op(2'd1, 5'd2, 5'd0, 5'd0, 5'd8, 1'b0, 1'b1, 32'd3);
        tick();
        stall = 1; mc_req_ready = 2'b01;
        #1;
        total++; if (mc_req_valid !== 2'b01) begin bad++; $display("FAIL fli_req got=%b want=01", mc_req_valid); end
        tick();
        clear_inputs();
        #1;
        total++;
        if (mc_req_valid !== 2'b00 || busy !== 1'b0 || ex_valid !== 1'b0) begin
            bad++; $display("FAIL fli_idle got req=%b busy=%b exv=%b want 00,0,0", mc_req_valid, busy, ex_valid);
        end
        tick();
    endtask

    task automatic test_flush_wait;
        id_op(2'd2, 5'd1, 5'd0, 5'd0, 5'd9, 1'b0, 1'b1, 32'd4);
        tick();
        mc_req_ready = 2'b10;
        #1;
        total++; if (mc_req_valid !== 2'b10) begin bad++; $display("FAIL flw_req got=%b want=10", mc_req_valid); end
        tick();
        mc_req_ready = 2'b00; stall = 1;
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL flw_stall_busy got=%b want=1", busy); end
        tick();
        clear_inputs();
        for (int c = 0; c < 3; c++) begin
            // c==1: response on the other unit must not end the drain
            mc_resp_valid = (c == 2) ? 2'b10 : ((c == 1) ? 2'b01 : 2'b00);
            mc_resp_data  = {32'hBEEF, 32'h1234};
            #1;
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL flw_drain_busy c=%0d got=%b want=1", c, busy); end
            tick();
        end
        clear_inputs();
        #1;
        total++;
        if (busy !== 1'b0 || ex_valid !== 1'b0 || mc_req_valid !== 2'b00) begin
            bad++; $display("FAIL flw_done got busy=%b exv=%b req=%b want 0,0,00", busy, ex_valid, mc_req_valid);
        end
        tick();
    endtask

    task automatic test_reset_issue;
        id_op(2'd1, 5'd2, 5'd0, 5'd0, 5'd10, 1'b0, 1'b1, 32'd5);
        tick();
        id_valid = 0;
        #1;
        total++; if (mc_req_valid !== 2'b01) begin bad++; $display("FAIL rsi_req got=%b want=01", mc_req_valid); end
        rst = 1;
        tick();
        rst = 0;
        #1;
        total++;
        if (mc_req_valid !== 2'b00 || busy !== 1'b0 || ex_valid !== 1'b0) begin
            bad++; $display("FAIL rsi_after got req=%b busy=%b exv=%b want 00,0,0", mc_req_valid, busy, ex_valid);
        end
        mc_resp_valid = 2'b01; mc_resp_data = {32'h0, 32'h5555};
        tick();
        clear_inputs();
        #1;
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL rsi_stray_resp got exv=%b want=0", ex_valid); end
        tick();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_back_to_back();
        test_class_isolation();
        test_priority();
        test_multicycle();
        test_flush_issue();
        test_flush_wait();
        test_reset_issue();
        tick();
        total++;
        if (q.size() != 0) begin
            bad++; $display("FAIL sb_leftover got=%0d pending want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exec_stage_mc.md
Name: exec_stage_mc

Overview:
Parametrised execute pipeline stage. It resolves operands with N-deep forwarding across separate int/float register classes. Single-cycle ops go through an external combinational ALU. Multi-cycle ops (FPU, divider, UART, ...) are dispatched to up to NUNIT external units over a valid/ready request and valid response handshake. Sits between decode and memory stages; registers all results into the EX/MEM pipeline register.

Parameters:
XLEN, 32, datapath width
RADDR, 5, register address width
NFWD, 2, forwarding sources beyond own EX output (index 0 = highest priority)
NUNIT, 2, external multi-cycle units
CTLW, 5, op control width
UW, $clog2(NUNIT+1), unit select width (localparam)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
stall  in  1  flush: inject bubble, abort pending op
id_valid  in  1  decode slot holds an instruction
id_ctl  in  CTLW  op control
id_unit  in  UW  0 = ALU, k = multi-cycle unit k-1
id_imm, id_pc  in  XLEN  immediate, PC
id_src_imm, id_src_pc  in  1  operand muxes (src2=imm, src1=pc)
id_rs1, id_rs2, id_rd  in  RADDR  register addresses
id_rs1_f, id_rs2_f, id_rd_f  in  1  register class, 1 = float
id_reg_write, id_mem_read, id_mem_write  in  1  control
rs1_data, rs2_data  in  XLEN  register-file read data
fwd_valid, fwd_f  in  NFWD  forward source writes, its class
fwd_rd  in  NFWD*RADDR  forward dest addresses
fwd_data  in  NFWD*XLEN  forward data
alu_a, alu_b  out  XLEN  resolved operands to ALU (combinational)
alu_ctl  out  CTLW  = id_ctl
alu_y  in  XLEN  ALU result
mc_req_valid  out  NUNIT  one-hot request
mc_req_ready  in  NUNIT  unit accepts
mc_op  out  CTLW  latched ctl
mc_a, mc_b  out  XLEN  latched operands
mc_resp_valid  in  NUNIT  result pulse
mc_resp_data  in  NUNIT*XLEN  results
busy  out  1  hold decode
ex_valid, ex_reg_write, ex_rd_f, ex_mem_read, ex_mem_write  out  1  EX/MEM control
ex_rd  out  RADDR  destination
ex_result, ex_store_data, ex_pc  out  XLEN  result, forwarded rs2, PC

Behaviour:
- Operand resolve, per rs:
  - addr==0 -> 0 in either class.
  - Else, first match on (addr, class) wins: own EX register (ex_valid && ex_reg_write), then fwd[0..NFWD-1] (fwd_valid), then rs*_data.
- src1 = id_src_pc ? id_pc : rs1; src2 = id_src_imm ? id_imm : rs2. alu_a/alu_b = src1/src2.
- FSM states: IDLE, ISSUE, WAIT, DRAIN. Reset -> IDLE; all ex_* outputs, mc_* regs and unit index reset to 0.
- IDLE:
  - id_valid && !stall && id_unit==0: EX register loads alu_y plus id_* control; ex_valid=1.
  - id_valid && !stall && id_unit!=0: latch src1/src2/ctl/unit, EX loads bubble, go ISSUE.
- ISSUE: mc_req_valid[u]=1 with latched operands. On mc_req_ready[u] -> WAIT. On stall -> IDLE (nothing issued).
- WAIT:
  - On mc_resp_valid[u]: EX loads mc_resp_data[u] with current id_* control (held stable by busy), then -> IDLE.
  - On stall: -> DRAIN, or -> IDLE if resp arrives in the same cycle.
  - Otherwise EX loads bubble.
- DRAIN: discard the next mc_resp_valid[u], then -> IDLE. busy=1 throughout.
- busy = (IDLE && id_valid && id_unit!=0 && !stall) || ISSUE || DRAIN || (WAIT && !mc_resp_valid[u]).
  - busy deasserts in the response cycle, so decode advances on the same edge the result retires (zero-bubble completion).
- Bubble means: ex_valid, ex_reg_write, ex_mem_* = 0; data outputs cleared to 0.
- stall has priority over every other event; EX register always loads a bubble when stall=1.
- ex_store_data = resolved rs2 (never imm).
- Response on an unselected unit is ignored.
- Reset mid-op returns to IDLE; no response is tracked after reset.

Decomposition:
- Shared package exec_pkg: state enum (IDLE/ISSUE/WAIT/DRAIN), UNIT_ALU=0, zero-register constant.
- Sub-module operand_fwd (one rs resolve, parametrised by NFWD), instantiated twice.

Test Plan:
- ALU back-to-back: addi x1,x0,5 then add x2,x1,x1 -> second ex_result=10 via own-EX forward; busy never 1.
- Class isolation: EX writes f3=0x3F800000, next reads int x3 (regfile 7) -> operand 7; next reads f3 -> 0x3F800000.
- Multi-cycle: unit 1, ready after 2 cycles, response 4 cycles later with 0xDEAD -> busy high 6 cycles, then ex_valid=1, ex_result=0xDEAD, id op advances same edge.
- Priority: fwd[0] and fwd[1] both write x5 (11, 22), regfile 33 -> operand 11.
- Flush in WAIT: stall pulse, response arrives 3 cycles later -> DRAIN swallows it, ex_valid stays 0, busy drops the cycle after response.
- Reset during ISSUE -> next cycle mc_req_valid=0, busy=0, ex_valid=0.
